// File: rtl/chip8_scanout_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chip8_scanout_pkg
//   Shared CHIP-8 display constants, VRAM address layout and the line-fetch
//   state encoding.
// ---------------------------------------------------------------------------
package chip8_scanout_pkg;

  localparam int CHIP8_WIDTH      = 64;
  localparam int CHIP8_HEIGHT     = 32;
  localparam int CHIP8_BYTE_WIDTH = 8;
  localparam int VRAM_AW          = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // VRAM layout: {buffer, row[4:0], byte[2:0]}
  function automatic logic [VRAM_AW-1:0] vram_addr(input logic       buf_sel,
                                                   input logic [4:0] row,
                                                   input logic [2:0] byte_idx);
    return {buf_sel, row, byte_idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_scanout_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chip8_scanout_if
//   VRAM read port between the scanout (master) and the frame buffer (slave).
//   Read data follows the strobe with a fixed 2-cycle latency.
// ---------------------------------------------------------------------------
interface chip8_scanout_if;

  logic                                  vram_rd_out;
  logic [chip8_scanout_pkg::VRAM_AW-1:0] vram_addr_out;
  logic [7:0]                            vram_data_in;

  modport master (output vram_rd_out, output vram_addr_out, input vram_data_in);
  modport slave  (input vram_rd_out, input vram_addr_out, output vram_data_in);

endinterface
`default_nettype wire

// File: rtl/chip8_line_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chip8_line_fetch
//   Reads one 64-pixel CHIP-8 row (8 bytes) from VRAM into a shadow register
//   and publishes it to the line register once every byte has returned.
// ---------------------------------------------------------------------------
module chip8_line_fetch
  import chip8_scanout_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   buf_sel,
  input  logic [4:0]             row,
  chip8_scanout_if.master        vram,
  output logic [CHIP8_WIDTH-1:0] line,
  output logic                   busy
);

  fetch_state_t           state;
  logic [1:0]             pipe;
  logic [2:0]             cap_idx;
  logic [CHIP8_WIDTH-1:0] shadow;

  assign busy = (state != ST_IDLE);

  // Read sequencer, valid pipe and shadow/line capture. The buffer bit is
  // latched into the address at start, so a swap can never split a line.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= ST_IDLE;
      vram.vram_rd_out   <= 1'b0;
      vram.vram_addr_out <= '0;
      pipe               <= 2'b00;
      cap_idx            <= 3'd0;
      shadow             <= '0;
      line               <= '0;
    end else begin
      pipe <= {pipe[0], vram.vram_rd_out};
      if (pipe[1]) begin
        shadow[{~cap_idx, 3'b111} -: CHIP8_BYTE_WIDTH] <= vram.vram_data_in;
        cap_idx <= cap_idx + 3'd1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state              <= ST_FETCH;
            vram.vram_rd_out   <= 1'b1;
            vram.vram_addr_out <= vram_addr(buf_sel, row, 3'd0);
            cap_idx            <= 3'd0;
          end else if (clear) begin
            line <= '0;
          end
        end
        ST_FETCH: begin
          if (vram.vram_addr_out[2:0] == 3'd7) begin
            vram.vram_rd_out <= 1'b0;
            state            <= ST_DRAIN;
          end else begin
            vram.vram_addr_out <= vram_addr(vram.vram_addr_out[8],
                                            vram.vram_addr_out[7:3],
                                            vram.vram_addr_out[2:0] + 3'd1);
          end
        end
        ST_DRAIN: begin
          if (pipe == 2'b00) begin
            state <= ST_IDLE;
            line  <= shadow;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/chip8_scanout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chip8_scanout
//   Display-side CHIP-8 frame buffer reader: prefetches each row during
//   horizontal blank, expands it to scaled 24-bit pixels, and owns the
//   front/back buffer select (swapped only at vsync while no fetch runs).
//   Optional feature macro: CHIP8_SCANOUT_BORDER_EN (2-pixel frame around
//   the game area).
// ---------------------------------------------------------------------------
module chip8_scanout
  import chip8_scanout_pkg::*;
#(
  parameter int          SCALE    = 16,
  parameter int          X_OFFSET = 128,
  parameter int          Y_OFFSET = 104,
  parameter int          ACTIVE_H = 1280,
  parameter int          V_TOTAL  = 750,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [10:0]     hcount_in,
  input  logic [9:0]      vcount_in,
  input  logic            vsync_in,
  input  logic            swap_req_in,
  output logic            swap_ack_out,
  output logic            front_sel_out,
  chip8_scanout_if.master vram,
  output logic [23:0]     pixel_out
);

  localparam int          SHIFT  = $clog2(SCALE);
  localparam logic [31:0] X_LO   = 32'(X_OFFSET);
  localparam logic [31:0] X_HI   = 32'(X_OFFSET + CHIP8_WIDTH * SCALE);
  localparam logic [31:0] Y_LO   = 32'(Y_OFFSET);
  localparam logic [31:0] Y_HI   = 32'(Y_OFFSET + CHIP8_HEIGHT * SCALE);
  localparam logic [31:0] H_TRIG = 32'(ACTIVE_H);
  localparam logic [31:0] V_LAST = 32'(V_TOTAL - 1);

  logic [31:0]            h, v, tgt;
  logic                   tgt_in, at_hblank, busy;
  logic [4:0]             row;
  logic [5:0]             col;
  logic [CHIP8_WIDTH-1:0] line;
  logic                   v_in, h_in;
  logic                   vsync_d, pending, want_swap;
  logic [23:0]            pix_next;

  assign h         = {21'd0, hcount_in};
  assign v         = {22'd0, vcount_in};
  assign tgt       = (v == V_LAST) ? 32'd0 : v + 32'd1;
  assign tgt_in    = (tgt >= Y_LO) && (tgt < Y_HI);
  assign at_hblank = (h == H_TRIG);
  assign row       = 5'((tgt - Y_LO) >> SHIFT);
  assign v_in      = (v >= Y_LO) && (v < Y_HI);
  assign h_in      = (h >= X_LO) && (h < X_HI);
  assign col       = 6'((h - X_LO) >> SHIFT);
  assign want_swap = pending | (vsync_in & ~vsync_d & swap_req_in);

  chip8_line_fetch u_fetch (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (at_hblank & tgt_in),
    .clear   (at_hblank & ~tgt_in),
    .buf_sel (front_sel_out),
    .row     (row),
    .vram    (vram),
    .line    (line),
    .busy    (busy)
  );

`ifdef CHIP8_SCANOUT_BORDER_EN
  logic side_cols, frame_rows, frame_cols;
  assign side_cols  = ((h + 32'd2 >= X_LO) && (h < X_LO)) || ((h >= X_HI) && (h < X_HI + 32'd2));
  assign frame_rows = ((v + 32'd2 >= Y_LO) && (v < Y_LO)) || ((v >= Y_HI) && (v < Y_HI + 32'd2));
  assign frame_cols = (h + 32'd2 >= X_LO) && (h < X_HI + 32'd2);
`endif

  // Colour lookup for the current beam position (~col == 63-col).
  always_comb begin
    pix_next = BG_COLOR;
    if (v_in && h_in) begin
      pix_next = line[~col] ? FG_COLOR : BG_COLOR;
    end
`ifdef CHIP8_SCANOUT_BORDER_EN
    if ((v_in && side_cols) || (frame_rows && frame_cols)) begin
      pix_next = FG_COLOR;
    end
`endif
  end

  // Pixel output register: one cycle behind hcount/vcount.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) pixel_out <= 24'd0;
    else         pixel_out <= pix_next;
  end

  // Buffer swap at a vsync rising edge; deferred while a line fetch is active.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vsync_d       <= 1'b0;
      pending       <= 1'b0;
      front_sel_out <= 1'b0;
      swap_ack_out  <= 1'b0;
    end else begin
      vsync_d      <= vsync_in;
      swap_ack_out <= 1'b0;
      if (want_swap) begin
        if (!busy) begin
          front_sel_out <= ~front_sel_out;
          swap_ack_out  <= 1'b1;
          pending       <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_scanout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_chip8_scanout
//   Directed self-checking bench for chip8_scanout with default parameters.
// ---------------------------------------------------------------------------
module tb_chip8_scanout;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
`ifdef CHIP8_SCANOUT_BORDER_EN
  localparam logic [23:0] BORDER = FG;
`else
  localparam logic [23:0] BORDER = BG;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync, swap_req, swap_ack, front_sel;
  logic [23:0] pixel;

  always #5 clk = ~clk;

  chip8_scanout_if vif ();

  chip8_scanout dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .vsync_in      (vsync),
    .swap_req_in   (swap_req),
    .swap_ack_out  (swap_ack),
    .front_sel_out (front_sel),
    .vram          (vif),
    .pixel_out     (pixel)
  );

  // VRAM model: 2-cycle read latency
  logic [7:0] mem [0:511];
  logic [7:0] d1;
  always @(posedge clk) begin
    d1               <= vif.vram_rd_out ? mem[vif.vram_addr_out] : 8'h00;
    vif.vram_data_in <= d1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic        s_rd    [20];
  logic [8:0]  s_addr  [20];
  logic        s_ack   [20];
  logic        s_front [20];
  logic [63:0] s_line  [20];

  // Drive one hblank (hcount 1280..1299) on line v; sample k follows edge k.
  task automatic sweep(input logic [9:0] v, input int vs_k, input int rst_k);
    vcount = v;
    for (int k = 0; k < 20; k++) begin
      hcount = 11'(1280 + k);
      if (k == vs_k) vsync = 1'b1;
      if (k == rst_k + 3) rst_n = 1'b1;
      @(negedge clk);
      s_rd[k]    = vif.vram_rd_out;
      s_addr[k]  = vif.vram_addr_out;
      s_ack[k]   = swap_ack;
      s_front[k] = front_sel;
      s_line[k]  = dut.line;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_rd", 64'(vif.vram_rd_out), 64'd0);
        check("rst_async_addr", 64'(vif.vram_addr_out), 64'd0);
        check("rst_async_pix", 64'(pixel), 64'd0);
      end
    end
  endtask

  function automatic int n_strobes();
    int n = 0;
    for (int k = 0; k < 20; k++) if (s_rd[k]) n++;
    return n;
  endfunction

  function automatic int n_acks();
    int n = 0;
    for (int k = 0; k < 20; k++) if (s_ack[k]) n++;
    return n;
  endfunction

  task automatic pix(input string tag, input logic [9:0] v, input logic [10:0] h, input logic [23:0] exp);
    vcount = v;
    hcount = h;
    @(negedge clk);
    check(tag, 64'(pixel), 64'(exp));
  endtask

  initial begin
    int acks;
    rst_n = 1'b0; hcount = '0; vcount = '0; vsync = 1'b0; swap_req = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h000] = 8'h80;
    mem[9'h0FF] = 8'h01;
    mem[9'h100] = 8'h40;

    repeat (3) @(negedge clk);
    check("reset_front", 64'(front_sel), 64'd0);
    check("reset_ack", 64'(swap_ack), 64'd0);
    check("reset_rd", 64'(vif.vram_rd_out), 64'd0);
    check("reset_addr", 64'(vif.vram_addr_out), 64'd0);
    check("reset_pix", 64'(pixel), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Row 0 fetch ahead of line 104
    sweep(10'd103, -1, -1);
    check("f0_strobes", 64'(n_strobes()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check("f0_rd", 64'(s_rd[k]), 64'd1);
      check("f0_addr", 64'(s_addr[k]), 64'(k));
    end
    check("f0_rd_end", 64'(s_rd[8]), 64'd0);
    check("f0_line_c10", s_line[10], 64'd0);
    check("f0_line_c11", s_line[11], 64'h8000_0000_0000_0000);

    pix("r0_x128", 10'd104, 11'd128, FG);
    pix("r0_x143", 10'd104, 11'd143, FG);
    pix("r0_x144", 10'd104, 11'd144, BG);
    pix("r0_x126", 10'd104, 11'd126, BORDER);
    pix("r0_x127", 10'd104, 11'd127, BORDER);

    // Row 31: last line of the region
    sweep(10'd614, -1, -1);
    check("f31_addr0", 64'(s_addr[0]), 64'h0F8);
    check("f31_line", s_line[12], 64'h1);
    pix("r31_x1151", 10'd615, 11'd1151, FG);
    pix("r31_x1135", 10'd615, 11'd1135, BG);

    // Below the region: no fetch, line cleared
    sweep(10'd615, -1, -1);
    check("out_strobes", 64'(n_strobes()), 64'd0);
    check("out_line_clr", s_line[1], 64'd0);
    pix("out_x1151", 10'd616, 11'd1151, BG);

    // Swap at a vsync edge while idle
    swap_req = 1'b1; vcount = '0; hcount = '0; vsync = 1'b1;
    @(negedge clk);
    check("swap_front", 64'(front_sel), 64'd1);
    check("swap_ack", 64'(swap_ack), 64'd1);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (swap_ack) acks++;
    end
    check("swap_no_reack", 64'(acks), 64'd0);
    vsync = 1'b0;
    @(negedge clk);

    sweep(10'd103, -1, -1);
    check("f1_strobes", 64'(n_strobes()), 64'd8);
    check("f1_addr0", 64'(s_addr[0]), 64'h100);
    check("f1_addr7", 64'(s_addr[7]), 64'h107);
    pix("b1_x144", 10'd104, 11'd144, FG);
    pix("b1_x128", 10'd104, 11'd128, BG);

    // vsync edge in the middle of a fetch: swap deferred until idle
    sweep(10'd103, 3, -1);
    check("pend_addr7", 64'(s_addr[7]), 64'h107);
    check("pend_front_c11", 64'(s_front[11]), 64'd1);
    check("pend_ack_c11", 64'(s_ack[11]), 64'd0);
    check("pend_front_c12", 64'(s_front[12]), 64'd0);
    check("pend_ack_c12", 64'(s_ack[12]), 64'd1);
    check("pend_ack_count", 64'(n_acks()), 64'd1);
    swap_req = 1'b0; vsync = 1'b0;
    @(negedge clk);

    // Reset during the 4th strobe aborts the fetch
    sweep(10'd103, -1, 3);
    check("rst_strobes", 64'(n_strobes()), 64'd4);
    check("rst_line", s_line[15], 64'd0);
    check("rst_front", 64'(s_front[15]), 64'd0);
    pix("rst_x128", 10'd104, 11'd128, BG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
